// File: rtl/halfstrip_hit_counter_if.sv
// Hit-counter bus: hit vector, window control and counter readback.
// master drives the controls, slave is the counter block.
interface halfstrip_hit_counter_if #(
   parameter int NHS   = 32,
   parameter int CNT_W = 16,
   parameter int WIN_W = 8
);
   logic [NHS-1:0]   halfstrips;
   logic             arm;
   logic [WIN_W-1:0] window_len;
   logic [4:0]       active_halfstrip;
   logic             mask_en;
   logic             clear;
   logic [4:0]       rd_adr;
   logic [CNT_W-1:0] rd_data;
   logic [CNT_W-1:0] event_cnt;
   logic [CNT_W-1:0] stray_cnt;
   logic [NHS-1:0]   last_hits;
   logic             busy;
   logic [WIN_W-1:0] first_hit_bx;

   modport master (
      output halfstrips, arm, window_len, active_halfstrip,
      output mask_en, clear, rd_adr,
      input  rd_data, event_cnt, stray_cnt, last_hits,
      input  busy, first_hit_bx
   );

   modport slave (
      input  halfstrips, arm, window_len, active_halfstrip,
      input  mask_en, clear, rd_adr,
      output rd_data, event_cnt, stray_cnt, last_hits,
      output busy, first_hit_bx
   );
endinterface

// File: rtl/halfstrip_hit_counter.sv
// Per-half-strip pulse hit counters with stray-hit and event statistics.
// Optional HALFSTRIP_HIT_COUNTER_LATENCY_EN adds first-hit latency capture.
module halfstrip_hit_counter #(
   parameter int NHS   = 32,
   parameter int CNT_W = 16,
   parameter int WIN_W = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   halfstrip_hit_counter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

   state_t           state;
   logic [WIN_W-1:0] len;
   logic [WIN_W-1:0] wcnt;
   logic [NHS-1:0]   acc;
   logic             busy_q;

   logic [CNT_W-1:0] cnt [NHS];
   logic [CNT_W-1:0] evt_q;
   logic [CNT_W-1:0] stray_q;
   logic [CNT_W-1:0] rd_q;
   logic [NHS-1:0]   last_q;

   logic [NHS-1:0]   others;
   logic             stray_hit;
   logic             closing;

   assign closing   = (state == CLOSE);
   assign others    = ~(NHS'(1) << bus.active_halfstrip);
   assign stray_hit = bus.mask_en && |(acc & others);

   // Window FSM: arm opens, len samples are ORed, one close cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         len    <= '0;
         wcnt   <= '0;
         acc    <= '0;
         busy_q <= 1'b0;
      end else if (bus.clear) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.arm) begin
                  len    <= (bus.window_len == '0) ?
                            WIN_W'(1) : bus.window_len;
                  acc    <= '0;
                  wcnt   <= '0;
                  busy_q <= 1'b1;
                  state  <= OPEN;
               end
            end
            OPEN: begin
               acc  <= acc | bus.halfstrips;
               wcnt <= wcnt + 1'b1;
               if (wcnt == len - 1'b1)
                  state <= CLOSE;
            end
            CLOSE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Saturating statistics, updated once per closed window.
   always_ff @(posedge clock) begin
      if (!reset || bus.clear) begin
         for (int i = 0; i < NHS; i++)
            cnt[i] <= '0;
         evt_q   <= '0;
         stray_q <= '0;
         last_q  <= '0;
      end else if (closing) begin
         for (int i = 0; i < NHS; i++)
            if (acc[i] && cnt[i] != '1)
               cnt[i] <= cnt[i] + 1'b1;
         if (evt_q != '1)
            evt_q <= evt_q + 1'b1;
         if (stray_hit && stray_q != '1)
            stray_q <= stray_q + 1'b1;
         last_q <= acc;
      end
   end

   // Registered counter readback, one cycle latency.
   always_ff @(posedge clock) begin
      if (!reset)
         rd_q <= '0;
      else
         rd_q <= cnt[bus.rd_adr];
   end

`ifdef HALFSTRIP_HIT_COUNTER_LATENCY_EN
   logic [WIN_W-1:0] lat_q;
   logic [WIN_W-1:0] fhb_q;
   logic             lat_seen;

   // First-hit latency inside the window; all-ones when nothing hit.
   always_ff @(posedge clock) begin
      if (!reset || bus.clear) begin
         lat_q    <= '0;
         lat_seen <= 1'b0;
         fhb_q    <= '0;
      end else begin
         if (state == IDLE && bus.arm) begin
            lat_seen <= 1'b0;
         end else if (state == OPEN && !lat_seen &&
                      |bus.halfstrips) begin
            lat_q    <= wcnt;
            lat_seen <= 1'b1;
         end
         if (closing)
            fhb_q <= lat_seen ? lat_q : '1;
      end
   end

   assign bus.first_hit_bx = fhb_q;
`else
   assign bus.first_hit_bx = '0;
`endif

   assign bus.rd_data   = rd_q;
   assign bus.event_cnt = evt_q;
   assign bus.stray_cnt = stray_q;
   assign bus.last_hits = last_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_halfstrip_hit_counter.sv
// Bench for halfstrip_hit_counter: directed and random windows
// checked against a per-window statistics model.
module tb_halfstrip_hit_counter;

   localparam int NHS   = 32;
   localparam int CNT_W = 8;
   localparam int WIN_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   halfstrip_hit_counter_if #(
      .NHS(NHS), .CNT_W(CNT_W), .WIN_W(WIN_W)
   ) bus ();

   halfstrip_hit_counter #(
      .NHS(NHS), .CNT_W(CNT_W), .WIN_W(WIN_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   int          m_cnt [NHS];
   int          m_evt;
   int          m_stray;
   logic [31:0] m_last;
   int          m_fhb;
   logic [31:0] hv [256];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      for (int i = 0; i < NHS; i++) m_cnt[i] = 0;
      m_evt   = 0;
      m_stray = 0;
      m_last  = '0;
      m_fhb   = 0;
   endtask

   task automatic check_stats(input string tag);
      chk({tag, ".event_cnt"}, 64'(bus.event_cnt), 64'(m_evt));
      chk({tag, ".stray_cnt"}, 64'(bus.stray_cnt), 64'(m_stray));
      chk({tag, ".last_hits"}, 64'(bus.last_hits), 64'(m_last));
      chk({tag, ".first_hit_bx"}, 64'(bus.first_hit_bx), 64'(m_fhb));
   endtask

   task automatic read_cnt(input string tag, input int idx);
      bus.rd_adr = 5'(idx);
      tick();
      chk(tag, 64'(bus.rd_data), 64'(m_cnt[idx]));
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      model_zero();
      chk("clear.event_cnt", 64'(bus.event_cnt), 64'd0);
   endtask

   // One window: hv[0..len-1] are the sampled hit vectors.
   task automatic run_window(input string tag, input int wl,
                             input int rearm_at, input logic men,
                             input int act, input logic arm_close,
                             input int rsel);
      int          eff;
      int          busy_n;
      int          first;
      logic [31:0] acc;
      eff = (wl == 0) ? 1 : wl;
      bus.window_len = WIN_W'(wl);
      bus.arm        = 1'b1;
      bus.halfstrips = $urandom;
      tick();
      bus.arm        = 1'b0;
      bus.window_len = WIN_W'($urandom);
      busy_n = bus.busy ? 1 : 0;
      acc    = '0;
      first  = -1;
      for (int k = 0; k < eff; k++) begin
         bus.halfstrips       = hv[k];
         bus.arm              = (k == rearm_at);
         bus.mask_en          = 1'($urandom);
         bus.active_halfstrip = 5'($urandom);
         acc = acc | hv[k];
         if (first < 0 && hv[k] != 0) first = k;
         tick();
         if (bus.busy) busy_n++;
      end
      bus.halfstrips       = $urandom;
      bus.mask_en          = men;
      bus.active_halfstrip = 5'(act);
      bus.arm              = arm_close;
      tick();
      bus.arm = 1'b0;
      for (int i = 0; i < NHS; i++)
         if (acc[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      if (m_evt < MAXC) m_evt++;
      if (men && (acc & ~(32'd1 << act)) != 0 && m_stray < MAXC)
         m_stray++;
      m_last = acc;
`ifdef HALFSTRIP_HIT_COUNTER_LATENCY_EN
      m_fhb = (first >= 0) ? first : (1 << WIN_W) - 1;
`else
      m_fhb = 0;
`endif
      chk({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
      chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(eff + 1));
      check_stats(tag);
      read_cnt({tag, ".rd_sel"}, rsel);
      read_cnt({tag, ".rd_rnd"}, $urandom_range(0, NHS - 1));
   endtask

   function automatic logic [31:0] rnd_hits(input int act);
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'd1 << $urandom_range(0, 31);
         2: return 32'd1 << act;
         3: return (32'd1 << act) | (32'd1 << $urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int act;
      int wl;
      model_zero();
      reset                = 1'b0;
      bus.halfstrips       = $urandom;
      bus.arm              = 1'b1;
      bus.window_len       = 8'd3;
      bus.active_halfstrip = '0;
      bus.mask_en          = 1'b0;
      bus.clear            = 1'b0;
      bus.rd_adr           = 5'd7;
      tick();
      tick();
      tick();
      bus.arm = 1'b0;
      chk("reset.busy", 64'(bus.busy), 64'd0);
      chk("reset.rd_data", 64'(bus.rd_data), 64'd0);
      check_stats("reset");
      reset = 1'b1;
      tick();
      chk("post_reset.busy", 64'(bus.busy), 64'd0);
      read_cnt("post_reset.rd", 7);

      // Single hit on the 2nd sample of a 4-long window.
      hv[0] = 32'h0; hv[1] = 32'h10; hv[2] = 32'h0; hv[3] = 32'h0;
      run_window("w4", 4, -1, 1'b0, 0, 1'b0, 4);

      // Stray accounting with mask on, then off.
      hv[0] = 32'h10; hv[1] = 32'h200;
      run_window("mask_on", 2, -1, 1'b1, 4, 1'b0, 9);
      run_window("mask_off", 2, -1, 1'b0, 4, 1'b0, 9);
      hv[0] = 32'h10; hv[1] = 32'h10;
      run_window("mask_clean", 2, -1, 1'b1, 4, 1'b0, 4);

      // Zero length acts as one sample; all strips hit once.
      do_clear();
      hv[0] = 32'hFFFF_FFFF;
      run_window("len0", 0, -1, 1'b0, 0, 1'b0, 31);
      for (int i = 0; i < NHS; i++) read_cnt("len0.sweep", i);

      // Re-arm inside a window and at close is ignored.
      do_clear();
      for (int k = 0; k < 10; k++) hv[k] = (k == 5) ? 32'h8 : 32'h0;
      run_window("rearm", 10, 3, 1'b0, 0, 1'b0, 3);
      hv[0] = 32'h0; hv[1] = 32'h0; hv[2] = 32'h1;
      run_window("arm_close", 3, -1, 1'b1, 0, 1'b1, 0);
      hv[0] = 32'h0;
      run_window("no_hit", 1, -1, 1'b1, 0, 1'b0, 0);

      // Clear aborts an open window and beats a same-cycle arm.
      hv[0] = 32'h10;
      run_window("pre_clear", 1, -1, 1'b0, 0, 1'b0, 4);
      bus.window_len = 8'd6;
      bus.arm        = 1'b1;
      tick();
      bus.arm        = 1'b0;
      bus.halfstrips = 32'h0000_0210;
      tick();
      tick();
      chk("abort.busy_open", 64'(bus.busy), 64'd1);
      bus.clear  = 1'b1;
      bus.arm    = 1'b1;
      bus.rd_adr = 5'd4;
      tick();
      bus.clear = 1'b0;
      bus.arm   = 1'b0;
      model_zero();
      chk("abort.busy", 64'(bus.busy), 64'd0);
      check_stats("abort");
      tick();
      chk("abort.rd_data", 64'(bus.rd_data), 64'd0);
      for (int k = 0; k < 8; k++) tick();
      chk("abort.no_close", 64'(bus.event_cnt), 64'd0);
      chk("abort.idle", 64'(bus.busy), 64'd0);
      read_cnt("abort.rd9", 9);
      hv[0] = 32'h200; hv[1] = 32'h0; hv[2] = 32'h4;
      run_window("after_abort", 3, -1, 1'b1, 9, 1'b0, 9);

      // Saturation of strip 0 and of the event counter.
      do_clear();
      hv[0] = 32'h1;
      for (int n = 0; n < MAXC + 2; n++)
         run_window("sat", 1, -1, 1'b0, 0, 1'b0, 0);
      chk("sat.evt_max", 64'(bus.event_cnt), 64'(MAXC));

      // Random windows, statistics carried across.
      do_clear();
      for (int n = 0; n < 150; n++) begin
         act = $urandom_range(0, 31);
         wl  = $urandom_range(0, 12);
         for (int k = 0; k < 13; k++) hv[k] = rnd_hits(act);
         run_window("rnd", wl,
                    ($urandom_range(0, 3) == 0) ?
                    $urandom_range(0, 11) : -1,
                    1'($urandom), act,
                    1'($urandom_range(0, 3) == 0),
                    $urandom_range(0, 31));
      end
      for (int i = 0; i < NHS; i++) read_cnt("final.sweep", i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/halfstrip_hit_counter.md
Name: halfstrip_hit_counter

Overview:
- Consumes the 32-bit half-strip hit vector produced by the eight triad decoders.
- For each comparator pulse, opens a capture window and ORs all half-strip hits seen during it.
- At window close, increments a per-half-strip saturating hit counter, an event counter, and a stray-hit counter.
- Counters are read back through the serial register interface. They provide pulse-efficiency and crosstalk statistics without per-pulse software polling.

Parameters:
- NHS, 32, number of half-strips (the width of `halfstrips`).
- CNT_W, 16, width of every hit, event and stray counter.
- WIN_W, 8, width of the capture-window length.

Ports:
- clock  in  1  40 MHz system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- halfstrips  in  NHS  half-strip hit vector from the triad decoders.
- arm  in  1  single-cycle strobe from the injector when a pulse fires.
- window_len  in  WIN_W  capture-window length in clocks; 0 is treated as 1.
- active_halfstrip  in  5  half-strip currently being pulsed.
- mask_en  in  1  when 1, hits on half-strips other than `active_halfstrip` count as stray.
- clear  in  1  synchronous clear of all counters.
- rd_adr  in  5  half-strip counter select.
- rd_data  out  CNT_W  registered hit count of half-strip `rd_adr`.
- event_cnt  out  CNT_W  number of windows closed.
- stray_cnt  out  CNT_W  number of windows containing at least one stray hit.
- last_hits  out  NHS  accumulated hit vector of the most recent window.
- busy  out  1  high while a window is open or closing.
- first_hit_bx  out  WIN_W  clocks from window open to the first non-zero `halfstrips` (optional feature).

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All hit counters, `event_cnt`, `stray_cnt`, `last_hits`, `rd_data` = 0.
  - busy=0, first_hit_bx=0.
- FSM has three states: IDLE, OPEN, CLOSE.
  - IDLE: busy=0. On `arm`=1: latch len = max(window_len,1), clear `acc`, wcnt=0, go to OPEN. `busy` rises the cycle after `arm`.
  - OPEN: acc <= acc | halfstrips every cycle; wcnt++.
    - When wcnt==len-1, the last sample is taken and the next state is CLOSE.
    - Exactly len cycles of `halfstrips` are sampled, starting the cycle after `arm`.
  - CLOSE: single cycle.
    - For each i with acc[i]=1: count[i]++, saturating at 2^CNT_W-1.
    - event_cnt++ (saturating).
    - If mask_en=1 and (acc & ~onehot(active_halfstrip)) != 0: stray_cnt++ (saturating).
    - last_hits <= acc.
    - Next state IDLE; busy=0 from the following cycle.
- `arm` while not in IDLE is ignored (no queueing). `arm` in the same cycle as the CLOSE-to-IDLE transition is also ignored.
- `active_halfstrip` and `mask_en` are sampled in the CLOSE cycle only.
- Saturation: a counter at its maximum holds; there is no wrap-around.
- `clear`=1 (priority over everything except reset):
  - All counters, `last_hits` and `first_hit_bx` go to 0.
  - Any open window is aborted: state=IDLE, no CLOSE update.
  - An `arm` in the same cycle is ignored.
- `rd_data` <= count[rd_adr] each cycle (1-cycle latency).
  - A read in the cycle after CLOSE returns the updated value.
  - `rd_data` reflects clear one cycle later (reads 0).
- Reset asserted mid-window behaves as clear plus reset values.
- NHS is fixed at 32, so `rd_adr` always addresses a valid counter.

Optional Feature:
- Macro: HALFSTRIP_HIT_COUNTER_LATENCY_EN.
- Defined:
  - At OPEN entry, an internal latency flag is cleared.
  - On the first OPEN cycle with halfstrips != 0, latency = wcnt and the flag is set.
  - In CLOSE: first_hit_bx <= latency if the flag is set, else all-ones (no hit).
  - Aborted windows do not update `first_hit_bx`.
- Undefined: `first_hit_bx` is tied to 0 and no latency logic is synthesised.

Test Plan:
- After reset, window_len=4, arm pulse, halfstrips=0x00000010 on the 2nd window cycle only -> CLOSE after 4 samples; count[4]=1, event_cnt=1, last_hits=0x10, busy high for 5 cycles; with macro, first_hit_bx=1.
- mask_en=1, active_halfstrip=4, hits on bits 4 and 9 in one window -> count[4]=1, count[9]=1, stray_cnt=1. Same again with mask_en=0 -> stray_cnt unchanged.
- window_len=0 with halfstrips=0xFFFFFFFF held -> a 1-sample window; all 32 counters =1, event_cnt=1.
- Second arm during OPEN (window_len=10, arm again at cycle 3) -> only one CLOSE, event_cnt=1.
- Force count[0] to 0xFFFE via 3 windows after preload… run windows until count[0]=0xFFFF, then 2 more -> stays 0xFFFF, event_cnt still incrementing.
- clear asserted during OPEN with hits present -> state IDLE next cycle, no CLOSE update, all counters 0, rd_data=0 one cycle later. A following arm works normally.
